// File: rtl/bot_update_sync.sv
// bot_update_sync
//   Bridges the rojobot register update strobe into the CPU clock domain and
//   presents a stable snapshot of the bot registers to the mfp_sys bot ports.
//   A pending flag is held until the CPU acknowledges it. Captured snapshots
//   and overrun updates are counted.
//
// Ports
//   clk            : CPU clock (clk_out)
//   rst            : synchronous, active-high reset
//   upd_sysregs_in : update strobe from rojobot, asynchronous to clk
//   bot_regs_in    : {LocX, LocY, Sensors, BotInfo} from rojobot
//   int_ack        : level acknowledge from PORT_INTACK
//   bot_info_out   : captured snapshot, to PORT_BOTINFO
//   bot_updt       : new snapshot pending, to PORT_BOTUPDT
//   upd_seq        : snapshots taken, wraps modulo 256
//   ovr_count      : updates that arrived while one was pending or waiting, saturating
module bot_update_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int CAPTURE_DELAY = 1,
  parameter int OVR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_sysregs_in,
  input  logic [31:0]      bot_regs_in,
  input  logic             int_ack,
  output logic [31:0]      bot_info_out,
  output logic             bot_updt,
  output logic [7:0]       upd_seq,
  output logic [OVR_W-1:0] ovr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam bit       NO_DELAY = (CAPTURE_DELAY == 0);
  localparam logic [3:0] CNT_INIT = NO_DELAY ? 4'd0 : 4'(CAPTURE_DELAY - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       capture;
  logic       ack_clr;
  logic       ovr_inc;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], upd_sysregs_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    ack_clr = 1'b0;
    ovr_inc = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (NO_DELAY) begin
            capture = 1'b1;
            state_n = PENDING;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (rise) begin
          cnt_n   = CNT_INIT;
          ovr_inc = 1'b1;
        end else if (cnt == 4'd0) begin
          capture = 1'b1;
          state_n = PENDING;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      PENDING: begin
        if (rise) begin
          // A simultaneous ack retires the old snapshot, so the new update is not an overrun.
          if (int_ack) ack_clr = 1'b1;
          else         ovr_inc = 1'b1;
          if (NO_DELAY) begin
            capture = 1'b1;
            state_n = PENDING;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end else if (int_ack) begin
          ack_clr = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bot_info_out <= '0;
      bot_updt     <= 1'b0;
      upd_seq      <= '0;
      ovr_count    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      // Capture takes priority so a zero-delay capture on an acked rise leaves the flag set.
      if (capture) begin
        bot_info_out <= bot_regs_in;
        bot_updt     <= 1'b1;
        upd_seq      <= upd_seq + 8'd1;
      end else if (ack_clr) begin
        bot_updt <= 1'b0;
      end
      if (ovr_inc && (ovr_count != '1)) begin
        ovr_count <= ovr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bot_update_sync.sv
// Testbench for bot_update_sync: event-level reference model plus directed
// scenarios with literal expectations.
module tb_bot_update_sync;
  localparam int S  = 2;
  localparam int D  = 1;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          upd;
  logic          ack;
  logic [31:0]   regs;
  logic [31:0]   bot_info_out;
  logic          bot_updt;
  logic [7:0]    upd_seq;
  logic [OW-1:0] ovr_count;

  bot_update_sync #(
    .SYNC_STAGES  (S),
    .CAPTURE_DELAY(D),
    .OVR_W        (OW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .upd_sysregs_in(upd),
    .bot_regs_in   (regs),
    .int_ack       (ack),
    .bot_info_out  (bot_info_out),
    .bot_updt      (bot_updt),
    .upd_seq       (upd_seq),
    .ovr_count     (ovr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: samples[k] is the input seen k+1 edges ago; a capture is
  // scheduled for an absolute edge number.
  bit          samples [0:S];
  logic [31:0] m_data;
  bit          m_updt;
  logic [7:0]  m_seq;
  int          m_ovr;
  int          cap_at;
  bit          m_rise;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic bump_ovr();
    if (m_ovr < (1 << OW) - 1) m_ovr++;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int k = 0; k <= S; k++) samples[k] = 1'b0;
      m_data = '0;
      m_updt = 1'b0;
      m_seq  = '0;
      m_ovr  = 0;
      cap_at = -1;
    end else begin
      m_rise = samples[S-1] && !samples[S];
      for (int k = S; k > 0; k--) samples[k] = samples[k-1];
      samples[0] = upd;
      if (m_rise) begin
        if (cap_at >= 0) bump_ovr();
        else if (m_updt) begin
          if (ack) m_updt = 1'b0;
          else     bump_ovr();
        end
        cap_at = cyc + D;
      end else if (cap_at < 0 && m_updt && ack) begin
        m_updt = 1'b0;
      end
      if (cap_at == cyc) begin
        m_data = regs;
        m_updt = 1'b1;
        m_seq  = m_seq + 8'd1;
        cap_at = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_bot_info", bot_info_out, m_data);
      check("m_bot_updt", {31'b0, bot_updt}, {31'b0, m_updt});
      check("m_upd_seq", {24'b0, upd_seq}, {24'b0, m_seq});
      check("m_ovr_count", 32'(ovr_count), 32'(m_ovr));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic pulse2();
    upd = 1'b1;
    tick(2);
    upd = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    upd  = 1'b0;
    ack  = 1'b0;
    regs = 32'hA5A5A5A5;

    // Reset state
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("rst_info", bot_info_out, 32'h0);
    check("rst_updt", {31'b0, bot_updt}, 32'h0);
    check("rst_seq", {24'b0, upd_seq}, 32'h0);
    check("rst_ovr", 32'(ovr_count), 32'h0);
    rst = 1'b0;
    tick(2);

    // Single update: latency boundary then ack
    regs = 32'h12345678;
    pulse2();
    tick(1);
    check("lat_edge3_updt", {31'b0, bot_updt}, 32'h0);
    tick(1);
    check("lat_edge4_updt", {31'b0, bot_updt}, 32'h1);
    check("single_info", bot_info_out, 32'h12345678);
    check("single_seq", {24'b0, upd_seq}, 32'h1);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_clears", {31'b0, bot_updt}, 32'h0);
    tick(2);

    // Overrun: two unacked updates ten clocks apart
    do_reset();
    regs = 32'h11;
    pulse2();
    tick(8);
    regs = 32'h22;
    pulse2();
    tick(6);
    check("ovr_info", bot_info_out, 32'h22);
    check("ovr_count1", 32'(ovr_count), 32'h1);
    check("ovr_seq", {24'b0, upd_seq}, 32'h2);
    check("ovr_updt", {31'b0, bot_updt}, 32'h1);

    // Collision: ack on the same edge as a rise while pending
    do_reset();
    regs = 32'h33;
    pulse2();
    tick(6);
    regs = 32'h44;
    pulse2();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("coll_updt_low", {31'b0, bot_updt}, 32'h0);
    check("coll_ovr", 32'(ovr_count), 32'h0);
    tick(1);
    check("coll_updt_high", {31'b0, bot_updt}, 32'h1);
    check("coll_info", bot_info_out, 32'h44);
    check("coll_seq", {24'b0, upd_seq}, 32'h2);

    // Ack held through IDLE, WAIT and the capture edge
    ack = 1'b1;
    tick(1);
    regs = 32'h55;
    pulse2();
    tick(2);
    check("held_ack_cap", {31'b0, bot_updt}, 32'h1);
    check("held_ack_info", bot_info_out, 32'h55);
    tick(1);
    check("held_ack_clr", {31'b0, bot_updt}, 32'h0);
    ack = 1'b0;
    tick(2);

    // Saturation and wrap: 300 unacked updates
    do_reset();
    for (int i = 0; i < 300; i++) begin
      regs = 32'(i);
      pulse2();
      tick(4);
    end
    tick(2);
    check("sat_ovr", 32'(ovr_count), 32'd255);
    check("wrap_seq", {24'b0, upd_seq}, 32'd44);
    check("sat_updt", {31'b0, bot_updt}, 32'h1);
    check("sat_info", bot_info_out, 32'd299);

    // Reset mid-WAIT, input held high afterwards
    do_reset();
    regs = 32'h66;
    upd  = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midwait_updt", {31'b0, bot_updt}, 32'h0);
    check("midwait_seq", {24'b0, upd_seq}, 32'h0);
    rst = 1'b0;
    tick(6);
    check("post_rst_seq", {24'b0, upd_seq}, 32'h1);
    check("post_rst_updt", {31'b0, bot_updt}, 32'h1);
    check("post_rst_info", bot_info_out, 32'h66);
    tick(10);
    check("held_single_seq", {24'b0, upd_seq}, 32'h1);
    upd = 1'b0;
    tick(3);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
